// File: rtl/apr_event_ctl.sv
// apr_event_ctl: width-generic APR event flag controller.
// Sticky per-channel event flags with interrupt enables, CONO-style
// set/clear/enable/disable commands, a PI assignment register, first-event
// capture and saturating per-channel occurrence counters, all readable
// through a combinational diagnostic mux.
module apr_event_ctl #(
    parameter int              NCH       = 8,
    parameter int              CNTW      = 4,
    parameter logic [NCH-1:0]  EDGE_MASK = '0,
    parameter int              PIAW      = 3,
    localparam int             IDXW      = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int             RDW       = (NCH > CNTW + IDXW + 1) ? NCH : CNTW + IDXW + 1
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic [NCH-1:0]   ebus_data,
    input  logic             sel_en,
    input  logic             sel_dis,
    input  logic             sel_set,
    input  logic             sel_clr,
    input  logic             load_pia,
    input  logic [PIAW-1:0]  pia_in,
    input  logic [NCH-1:0]   ev_src,
    input  logic [1:0]       diag_sel,
    input  logic [IDXW-1:0]  rd_ch,
    output logic [RDW-1:0]   rd_data,
    output logic [NCH-1:0]   flag,
    output logic [NCH-1:0]   int_en,
    output logic             apr_interrupt,
    output logic [PIAW-1:0]  pia,
    output logic             any_err_flg,
    output logic             first_valid,
    output logic [IDXW-1:0]  first_idx
);

    // Counter increment that sticks at all-ones.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
        return (&c) ? c : c + CNTW'(1);
    endfunction

    // Index of the lowest set bit (0 when none are set).
    function automatic logic [IDXW-1:0] lowest_idx(input logic [NCH-1:0] v);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (v[i]) idx = IDXW'(i);
        end
        return idx;
    endfunction

    logic [NCH-1:0]  src_q;
    logic [NCH-1:0]  hit;
    logic [NCH-1:0]  set_m;
    logic [NCH-1:0]  clr_m;
    logic [NCH-1:0]  en_m;
    logic [NCH-1:0]  dis_m;
    logic [NCH-1:0]  flag_nxt;
    logic [NCH-1:0]  int_en_nxt;
    logic [NCH-1:0]  rise;
    logic [CNTW-1:0] cnt [NCH];

    // Event detection and next-state flag / enable terms; hit and set beat clear.
    always_comb begin
        hit        = (EDGE_MASK & ev_src & ~src_q) | (~EDGE_MASK & ev_src);
        set_m      = {NCH{sel_set}} & ebus_data;
        clr_m      = {NCH{sel_clr}} & ebus_data;
        en_m       = {NCH{sel_en}}  & ebus_data;
        dis_m      = {NCH{sel_dis}} & ebus_data;
        flag_nxt   = hit | set_m | (flag & ~clr_m);
        int_en_nxt = en_m | (int_en & ~dis_m);
        rise       = flag_nxt & ~flag;
    end

    // Control state: flags, enables, source history, PIA and first-event capture.
    always_ff @(posedge clk) begin
        if (RESET) begin
            flag        <= '0;
            int_en      <= '0;
            src_q       <= '0;
            pia         <= '0;
            any_err_flg <= 1'b0;
            first_valid <= 1'b0;
            first_idx   <= '0;
        end else begin
            flag        <= flag_nxt;
            int_en      <= int_en_nxt;
            src_q       <= ev_src;
            any_err_flg <= |flag_nxt;
            if (load_pia) pia <= pia_in;
            // A newly rising flag is captured before an all-clear can drop first_valid.
            if (!first_valid && (|rise)) begin
                first_valid <= 1'b1;
                first_idx   <= lowest_idx(rise);
            end else if (!(|flag_nxt)) begin
                first_valid <= 1'b0;
            end
        end
    end

    // Occurrence counters: a clear with a simultaneous hit restarts at one.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (RESET) begin
                cnt[i] <= '0;
            end else if (clr_m[i]) begin
                cnt[i] <= hit[i] ? CNTW'(1) : '0;
            end else if (hit[i]) begin
                cnt[i] <= sat_inc(cnt[i]);
            end
        end
    end

    // Diagnostic read mux, zero-extended; out-of-range channels read zero.
    always_comb begin
        rd_data = '0;
        case (diag_sel)
            2'd0: rd_data = RDW'(flag);
            2'd1: rd_data = RDW'(int_en);
            2'd2: rd_data = RDW'({first_valid, first_idx});
            default: begin
                if (int'(rd_ch) < NCH) rd_data = RDW'(cnt[rd_ch]);
            end
        endcase
    end

    assign apr_interrupt = |(flag & int_en);

endmodule

// File: tb/tb_apr_event_ctl.sv
// Testbench for apr_event_ctl (NCH=8, CNTW=4, EDGE_MASK=8'h01, PIAW=3):
// directed scenarios followed by random traffic, all compared against a
// behavioural model of the event rules.
module tb_apr_event_ctl;

    localparam logic [7:0] EMASK = 8'h01;

    logic       clk = 1'b0;
    logic       RESET;
    logic [7:0] ebus_data;
    logic       sel_en, sel_dis, sel_set, sel_clr, load_pia;
    logic [2:0] pia_in;
    logic [7:0] ev_src;
    logic [1:0] diag_sel;
    logic [2:0] rd_ch;
    logic [7:0] rd_data;
    logic [7:0] flag, int_en;
    logic       apr_interrupt;
    logic [2:0] pia;
    logic       any_err_flg, first_valid;
    logic [2:0] first_idx;

    apr_event_ctl #(.NCH(8), .CNTW(4), .EDGE_MASK(EMASK), .PIAW(3)) dut (
        .clk(clk), .RESET(RESET), .ebus_data(ebus_data),
        .sel_en(sel_en), .sel_dis(sel_dis), .sel_set(sel_set), .sel_clr(sel_clr),
        .load_pia(load_pia), .pia_in(pia_in), .ev_src(ev_src),
        .diag_sel(diag_sel), .rd_ch(rd_ch), .rd_data(rd_data),
        .flag(flag), .int_en(int_en), .apr_interrupt(apr_interrupt), .pia(pia),
        .any_err_flg(any_err_flg), .first_valid(first_valid), .first_idx(first_idx)
    );

    always #50 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    bit [7:0] m_flag, m_en, m_src;
    bit [2:0] m_pia;
    bit       m_fv, m_any;
    int       m_fidx;
    int       m_cnt [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit [7:0] nf;
        bit       h, found;
        if (RESET) begin
            m_flag = 0; m_en = 0; m_src = 0; m_pia = 0;
            m_fv = 0; m_fidx = 0; m_any = 0;
            for (int i = 0; i < 8; i++) m_cnt[i] = 0;
            return;
        end
        nf = 0;
        for (int i = 0; i < 8; i++) begin
            if (EMASK[i]) h = ev_src[i] && !m_src[i];
            else          h = ev_src[i];
            nf[i] = h || (sel_set && ebus_data[i]) || (m_flag[i] && !(sel_clr && ebus_data[i]));
            if (sel_clr && ebus_data[i]) m_cnt[i] = h ? 1 : 0;
            else if (h)                  m_cnt[i] = (m_cnt[i] + 1 > 15) ? 15 : m_cnt[i] + 1;
            if (sel_en && ebus_data[i])       m_en[i] = 1'b1;
            else if (sel_dis && ebus_data[i]) m_en[i] = 1'b0;
        end
        found = 0;
        if (!m_fv) begin
            for (int i = 0; i < 8; i++) begin
                if (!found && nf[i] && !m_flag[i]) begin
                    found = 1; m_fidx = i;
                end
            end
            if (found) m_fv = 1;
        end else if (nf == 0) begin
            m_fv = 0;
        end
        m_flag = nf;
        m_any  = (nf != 0);
        m_src  = ev_src;
        if (load_pia) m_pia = pia_in;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] sel, input logic [2:0] ch, output logic [7:0] val);
        diag_sel = sel;
        rd_ch    = ch;
        #1;
        val = rd_data;
    endtask

    // Compare every output and every diagnostic view against the model.
    task automatic check_state(input string tag);
        logic [7:0] v;
        chk({tag, ".flag"},  flag,          m_flag);
        chk({tag, ".inten"}, int_en,        m_en);
        chk({tag, ".irq"},   apr_interrupt, |(m_flag & m_en));
        chk({tag, ".pia"},   pia,           m_pia);
        chk({tag, ".any"},   any_err_flg,   m_any);
        chk({tag, ".fv"},    first_valid,   m_fv);
        chk({tag, ".fidx"},  first_idx,     m_fidx[2:0]);
        rd(2'd0, 3'd0, v); chk({tag, ".rd0"}, v, m_flag);
        rd(2'd1, 3'd0, v); chk({tag, ".rd1"}, v, m_en);
        rd(2'd2, 3'd0, v); chk({tag, ".rd2"}, v, {4'd0, m_fv, m_fidx[2:0]});
        for (int i = 0; i < 8; i++) begin
            rd(2'd3, 3'(i), v);
            chk({tag, ".rdcnt"}, v, m_cnt[i][7:0]);
        end
    endtask

    task automatic idle_cmds();
        ebus_data = 0; sel_en = 0; sel_dis = 0; sel_set = 0; sel_clr = 0; load_pia = 0;
    endtask

    initial begin
        logic [7:0] v;
        RESET = 1; idle_cmds(); pia_in = 0; ev_src = 8'hFF; diag_sel = 0; rd_ch = 0;
        #1;

        // Reset with all sources high
        tick(); tick();
        chk("rst.flag", flag, 8'h00);
        chk("rst.inten", int_en, 8'h00);
        chk("rst.pia", pia, 3'd0);
        chk("rst.irq", apr_interrupt, 1'b0);
        chk("rst.fv", first_valid, 1'b0);
        check_state("rst");
        RESET = 0; ev_src = 0;
        tick(); check_state("post_rst");

        // Enable channel 2 then pulse its source
        sel_en = 1; ebus_data = 8'h04; tick(); check_state("en2");
        idle_cmds(); ev_src = 8'h04; tick(); ev_src = 0;
        chk("ev2.flag", flag, 8'h04);
        chk("ev2.irq", apr_interrupt, 1'b1);
        chk("ev2.fidx", first_idx, 3'd2);
        chk("ev2.fv", first_valid, 1'b1);
        rd(2'd3, 3'd2, v); chk("ev2.cnt2", v, 8'd1);
        check_state("ev2");

        // Clear everything, then set/clear collision on level channel 5
        sel_clr = 1; ebus_data = 8'hFF; tick(); check_state("clrall");
        idle_cmds(); sel_set = 1; ebus_data = 8'h20; tick(); check_state("set5");
        idle_cmds(); sel_clr = 1; ebus_data = 8'h20; ev_src = 8'h20; tick();
        chk("coll.flag5", flag[5], 1'b1);
        rd(2'd3, 3'd5, v); chk("coll.cnt5", v, 8'd1);
        check_state("coll");
        idle_cmds(); ev_src = 0; tick(); check_state("drop5");
        sel_clr = 1; ebus_data = 8'h20; tick();
        chk("clr5.flag", flag, 8'h00);
        chk("clr5.fv", first_valid, 1'b0);
        check_state("clr5");
        idle_cmds();

        // Edge channel 0 held for 10 cycles, level channel 1 held for 20
        ev_src = 8'h01;
        for (int i = 0; i < 10; i++) begin tick(); check_state("edge0"); end
        rd(2'd3, 3'd0, v); chk("edge.cnt0", v, 8'd1);
        ev_src = 8'h02;
        for (int i = 0; i < 20; i++) begin tick(); check_state("lvl1"); end
        rd(2'd3, 3'd1, v); chk("lvl.cnt1", v, 8'd15);
        ev_src = 0; tick();
        sel_clr = 1; ebus_data = 8'hFF; tick(); check_state("clrall2");
        idle_cmds();

        // Simultaneous first events, later event does not move capture
        ev_src = 8'h48; tick(); ev_src = 0;
        chk("sim.fidx", first_idx, 3'd3);
        check_state("sim");
        ev_src = 8'h02; tick(); ev_src = 0;
        chk("later.fidx", first_idx, 3'd3);
        check_state("later");

        // Enable/disable collision and PIA load
        sel_dis = 1; ebus_data = 8'hFF; tick(); idle_cmds();
        sel_en = 1; sel_dis = 1; ebus_data = 8'h80; tick(); idle_cmds();
        chk("endis.int7", int_en[7], 1'b1);
        load_pia = 1; pia_in = 3'd5; tick(); idle_cmds();
        chk("pia.load", pia, 3'd5);
        rd(2'd1, 3'd0, v); chk("pia.rd1", v, 8'h80);
        check_state("pia");

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            RESET     = ($urandom_range(31) == 0);
            ebus_data = 8'($urandom);
            sel_en    = ($urandom_range(3) == 0);
            sel_dis   = ($urandom_range(3) == 0);
            sel_set   = ($urandom_range(3) == 0);
            sel_clr   = ($urandom_range(3) == 0);
            load_pia  = ($urandom_range(3) == 0);
            pia_in    = 3'($urandom);
            ev_src    = 8'($urandom) & 8'($urandom);
            tick();
            check_state("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
